// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among num_req_p byte requesters.
// Define UART_TX_ARB_LOCK_EN to hold the grant until a byte marked last has completed.
module uart_tx_arbiter #(
   parameter int unsigned num_req_p   = 4,
   parameter int unsigned data_bits_p = 8
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic [num_req_p-1:0]             req_v_i,
   input  logic [num_req_p*data_bits_p-1:0] req_data_i,
   input  logic [num_req_p-1:0]             req_last_i,
   output logic [num_req_p-1:0]             req_ready_and_o,
   output logic                             tx_v_o,
   output logic [data_bits_p-1:0]           tx_data_o,
   input  logic                             tx_ready_and_i,
   input  logic                             tx_done_i,
   output logic [$clog2(num_req_p)-1:0]     grant_o,
   output logic                             busy_o
);

   localparam int unsigned gw_lp = $clog2(num_req_p);

   typedef enum logic [1:0] {e_arb, e_issue, e_wait} state_e;

   state_e           state_r, state_n;
   logic [gw_lp-1:0] grant_r, grant_n;
   logic [gw_lp-1:0] rr_ptr_r, rr_ptr_n;
   logic             last_r, last_n;
   logic [gw_lp-1:0] pick;
   logic             pick_v;
   logic [gw_lp-1:0] grant_inc;
   logic             release_grant;

`ifdef UART_TX_ARB_LOCK_EN
   assign release_grant = last_r;
`else
   logic unused_last;
   assign release_grant = 1'b1;
   assign unused_last   = ^{last_r, req_last_i};
`endif

   // First valid requester at or after rr_ptr_r, wrapping modulo num_req_p.
   always_comb begin
      int unsigned idx;
      idx    = 0;
      pick   = '0;
      pick_v = 1'b0;
      for (int unsigned i = 0; i < num_req_p; i++) begin
         idx = 32'(rr_ptr_r) + i;
         if (idx >= num_req_p) idx = idx - num_req_p;
         if (!pick_v && req_v_i[idx[gw_lp-1:0]]) begin
            pick   = idx[gw_lp-1:0];
            pick_v = 1'b1;
         end
      end
   end

   assign grant_inc = (grant_r == gw_lp'(num_req_p - 1)) ? '0 : grant_r + 1'b1;

   always_comb begin
      state_n         = state_r;
      grant_n         = grant_r;
      rr_ptr_n        = rr_ptr_r;
      last_n          = last_r;
      req_ready_and_o = '0;
      tx_v_o          = 1'b0;
      tx_data_o       = '0;
      case (state_r)
         e_arb: begin
            if (pick_v) begin
               grant_n = pick;
               state_n = e_issue;
            end
         end
         e_issue: begin
            tx_v_o                   = req_v_i[grant_r];
            req_ready_and_o[grant_r] = tx_ready_and_i;
            if (req_v_i[grant_r]) begin
               tx_data_o = req_data_i[32'(grant_r)*data_bits_p +: data_bits_p];
               if (tx_ready_and_i) begin
                  last_n  = req_last_i[grant_r];
                  state_n = e_wait;
               end
            end
         end
         e_wait: begin
            if (tx_done_i) begin
               if (release_grant) begin
                  rr_ptr_n = grant_inc;
                  state_n  = e_arb;
               end else begin
                  state_n  = e_issue;
               end
            end
         end
         default: state_n = e_arb;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r  <= e_arb;
         grant_r  <= '0;
         rr_ptr_r <= '0;
         last_r   <= 1'b0;
      end else begin
         state_r  <= state_n;
         grant_r  <= grant_n;
         rr_ptr_r <= rr_ptr_n;
         last_r   <= last_n;
      end
   end

   assign busy_o  = (state_r != e_arb);
   assign grant_o = grant_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requester drivers, a randomized uart_tx
// model and a message-level round-robin reference model; honours UART_TX_ARB_LOCK_EN.
module tb_uart_tx_arbiter;

   localparam int NUM = 4;
   localparam int DW  = 8;
`ifdef UART_TX_ARB_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NUM-1:0]    req_v, req_last, req_ready;
   logic [NUM*DW-1:0] req_data;
   logic              tx_v, tx_ready, tx_done, busy;
   logic [DW-1:0]     tx_data;
   logic [1:0]        grant;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.num_req_p(NUM), .data_bits_p(DW)) dut (
      .clk_i           (clk),
      .reset_n_i       (reset_n),
      .req_v_i         (req_v),
      .req_data_i      (req_data),
      .req_last_i      (req_last),
      .req_ready_and_o (req_ready),
      .tx_v_o          (tx_v),
      .tx_data_o       (tx_data),
      .tx_ready_and_i  (tx_ready),
      .tx_done_i       (tx_done),
      .grant_o         (grant),
      .busy_o          (busy)
   );

   typedef struct { logic [7:0] data; logic last; int gap; } ent_t;
   typedef struct { int req; logic [7:0] data; } exp_t;

   ent_t           rq [NUM][$];
   int             gap_cnt [NUM];
   exp_t           expq[$];
   int             mptr;
   int             checks = 0;
   int             errors = 0;
   logic [NUM-1:0] hs_req = '0;
   logic           hs_tx  = 1'b0;
   logic           u_busy = 1'b0;
   int             u_cnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [NUM-1:0] onehot(input int r);
      onehot    = '0;
      onehot[r] = 1'b1;
   endfunction

   function automatic int pending();
      pending = 0;
      for (int k = 0; k < NUM; k++) pending += rq[k].size();
   endfunction

   function automatic void drive_reqs();
      for (int k = 0; k < NUM; k++) begin
         if (rq[k].size() > 0 && gap_cnt[k] == 0) begin
            req_v[k]            = 1'b1;
            req_data[k*DW +: DW] = rq[k][0].data;
            req_last[k]         = rq[k][0].last;
         end else begin
            req_v[k]            = 1'b0;
            req_data[k*DW +: DW] = '0;
            req_last[k]         = 1'b0;
         end
      end
   endfunction

   // Reference: serve queued messages round robin from mptr, one byte or one whole message per grant.
   task automatic build_expected();
      ent_t tmp [NUM][$];
      ent_t e;
      int   r;
      logic fin;
      for (int k = 0; k < NUM; k++) tmp[k] = rq[k];
      while (1) begin
         r = -1;
         for (int i = 0; i < NUM; i++)
            if (r < 0 && tmp[(mptr + i) % NUM].size() > 0) r = (mptr + i) % NUM;
         if (r < 0) break;
         do begin
            e = tmp[r].pop_front();
            expq.push_back('{req: r, data: e.data});
            fin = LOCK ? e.last : 1'b1;
         end while (!fin && tmp[r].size() > 0);
         mptr = (r + 1) % NUM;
      end
   endtask

   task automatic add_byte(input int r, input logic [7:0] d, input logic last, input int gap);
      rq[r].push_back('{data: d, last: last, gap: gap});
   endtask

   task automatic wait_drain(input string name);
      int cyc = 0;
      while ((expq.size() > 0 || pending() > 0 || busy) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_timeout"}, 32'(cyc >= 3000), 0);
      check({name, "_idle_busy"}, {31'd0, busy}, 0);
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      expq.delete();
      mptr = 0;
      for (int k = 0; k < NUM; k++) begin
         rq[k].delete();
         gap_cnt[k] = 0;
      end
      repeat (3) @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #2;
   endtask

   // Monitor: pops the scoreboard on every uart handshake and checks output rules each cycle.
   always @(negedge clk) begin
      exp_t e;
      hs_req = '0;
      hs_tx  = 1'b0;
      if (reset_n) begin
         hs_req = req_v & req_ready;
         hs_tx  = tx_v & tx_ready;
         if (!tx_v) check("data_zero_when_idle", 32'(tx_data), 0);
         if (!busy) check("idle_outputs", {27'd0, req_ready, tx_v}, 0);
         else       check("ready_only_owner", 32'(req_ready & ~onehot(int'(grant))), 0);
         if (hs_tx) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %0h from %0d expected none", tx_data, grant);
            end else begin
               e = expq.pop_front();
               check("tx_data", 32'(tx_data), 32'(e.data));
               check("tx_owner", 32'(grant), 32'(e.req));
               check("req_handshake", 32'(hs_req), 32'(onehot(e.req)));
            end
         end
      end
   end

   // Requester drivers and uart_tx model, updated just after each rising edge.
   always @(posedge clk) begin
      #1;
      tx_done = 1'b0;
      for (int k = 0; k < NUM; k++) begin
         if (hs_req[k] && rq[k].size() > 0) begin
            void'(rq[k].pop_front());
            gap_cnt[k] = (rq[k].size() > 0) ? rq[k][0].gap : 0;
         end else if (gap_cnt[k] > 0) begin
            gap_cnt[k]--;
         end
      end
      if (!reset_n) begin
         u_busy   = 1'b0;
         tx_ready = 1'b0;
      end else if (hs_tx) begin
         u_busy   = 1'b1;
         u_cnt    = $urandom_range(1, 6);
         tx_ready = 1'b0;
      end else if (u_busy) begin
         if (u_cnt == 0) begin
            tx_done = 1'b1;
            u_busy  = 1'b0;
         end else begin
            u_cnt--;
         end
      end else begin
         tx_ready = ($urandom_range(0, 3) != 0);
         tx_done  = ($urandom_range(0, 7) == 0);
      end
      drive_reqs();
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      int nmsg, len;
      reset_n  = 1'b0;
      req_v    = '0;
      req_last = '0;
      req_data = '0;
      tx_ready = 1'b0;
      tx_done  = 1'b0;
      for (int k = 0; k < NUM; k++) gap_cnt[k] = 0;
      mptr = 0;
      #1;
      check("rst_tx_v", {31'd0, tx_v}, 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_grant", 32'(grant), 0);
      do_reset();

      // single requester 2, then wrap from pointer 3 with requests from 0 and 3
      add_byte(2, 8'hA5, 1'b1, 0);
      build_expected();
      wait_drain("single");
      add_byte(0, 8'h0F, 1'b1, 0);
      add_byte(3, 8'h3F, 1'b1, 0);
      build_expected();
      wait_drain("wrap");

      // full contention from pointer 0
      do_reset();
      add_byte(0, 8'hA0, 1'b1, 0);
      add_byte(0, 8'hA4, 1'b1, 0);
      add_byte(1, 8'hA1, 1'b1, 0);
      add_byte(2, 8'hA2, 1'b1, 0);
      add_byte(3, 8'hA3, 1'b1, 0);
      build_expected();
      wait_drain("contention");

      // multi-byte message from 1 competing with 0
      do_reset();
      add_byte(0, 8'h55, 1'b1, 0);
      build_expected();
      wait_drain("prime");
      add_byte(1, 8'h11, 1'b0, 0);
      add_byte(1, 8'h22, 1'b0, 0);
      add_byte(1, 8'h33, 1'b1, 0);
      add_byte(0, 8'h44, 1'b1, 0);
      build_expected();
      wait_drain("message");

`ifdef UART_TX_ARB_LOCK_EN
      // owner stalls 50 cycles mid-message; grant must be held
      do_reset();
      add_byte(1, 8'h60, 1'b0, 0);
      add_byte(1, 8'h61, 1'b1, 50);
      add_byte(2, 8'h70, 1'b1, 0);
      build_expected();
      for (int c = 0; c < 500 && expq.size() > 2; c++) @(negedge clk);
      repeat (20) @(negedge clk);
      check("hold_grant", 32'(grant), 1);
      check("hold_busy", {31'd0, busy}, 1);
      check("hold_no_other_ready", {31'd0, req_ready[2]}, 0);
      check("hold_tx_v", {31'd0, tx_v}, 0);
      wait_drain("hold");
`endif

      // reset while a frame is in flight
      do_reset();
      add_byte(2, 8'h5A, 1'b1, 0);
      build_expected();
      wait_drain("pre_abort");
      add_byte(3, 8'hC3, 1'b1, 0);
      add_byte(1, 8'hC1, 1'b1, 0);
      add_byte(0, 8'hC0, 1'b1, 0);
      build_expected();
      for (int c = 0; c < 500 && expq.size() > 2; c++) begin
         @(negedge clk);
         #1;
      end
      check("abort_first_served", 32'(expq.size()), 2);
      @(posedge clk);
      #3;
      check("abort_busy_before", {31'd0, busy}, 1);
      reset_n = 1'b0;
      #1;
      check("abort_tx_v", {31'd0, tx_v}, 0);
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_ready", 32'(req_ready), 0);
      check("abort_grant", 32'(grant), 0);
      expq.delete();
      mptr = 0;
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      build_expected();
      wait_drain("after_abort");

      // randomized traffic
      for (int t = 0; t < 12; t++) begin
         for (int k = 0; k < NUM; k++) begin
            nmsg = $urandom_range(0, 3);
            for (int m = 0; m < nmsg; m++) begin
               len = $urandom_range(1, 3);
               for (int b = 0; b < len; b++)
                  add_byte(k, 8'($urandom),
                           LOCK ? (b == len - 1) : 1'($urandom_range(0, 1)),
                           (LOCK && b > 0) ? $urandom_range(0, 4) : 0);
            end
         end
         build_expected();
         wait_drain("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: num_req_p, default 4, number of requesters sharing one uart_tx (2..16).
REQ-002 Parameter: data_bits_p, default 8, byte width, identical to the attached uart_tx data_bits_p.
REQ-003 Port: clk_i  input  1  single clock; all state updates on posedge.
REQ-004 Port: reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 Port: req_v_i  input  num_req_p  per-requester byte valid.
REQ-006 Port: req_data_i  input  num_req_p*data_bits_p  per-requester byte; requester k occupies bits [k*data_bits_p +: data_bits_p].
REQ-007 Port: req_last_i  input  num_req_p  marks the final byte of a requester's message; sampled with the byte.
REQ-008 Port: req_ready_and_o  output  num_req_p  per-requester accept; a byte transfers when v and ready_and are both high.
REQ-009 Port: tx_v_o  output  1  valid to uart_tx tx_v_i.
REQ-010 Port: tx_data_o  output  data_bits_p  byte to uart_tx tx_i.
REQ-011 Port: tx_ready_and_i  input  1  from uart_tx tx_ready_and_o.
REQ-012 Port: tx_done_i  input  1  from uart_tx tx_done_o; one-cycle pulse at end of frame.
REQ-013 Port: grant_o  output  clog2(num_req_p)  index of current owner; valid when busy_o is high.
REQ-014 Port: busy_o  output  1  high in any state other than e_arb.

Function
REQ-015 FSM states: e_arb, e_issue, e_wait.
REQ-016 e_arb: if any req_v_i is high, the first requester at or after rr_ptr (wrapping modulo num_req_p) is registered as grant and the FSM moves to e_issue; otherwise it stays in e_arb.
REQ-017 e_arb: tx_v_o and all req_ready_and_o are low.
REQ-018 e_issue: tx_v_o = req_v_i[grant], tx_data_o = granted byte, req_ready_and_o[grant] = tx_ready_and_i, all other ready bits low (combinational pass-through, zero added latency).
REQ-019 e_issue: on handshake (req_v_i[grant] & tx_ready_and_i), last_r captures req_last_i[grant] and the FSM moves to e_wait.
REQ-020 e_wait: tx_v_o and all ready bits low; on tx_done_i the byte is complete.
REQ-021 e_wait exit on tx_done_i: if the owner keeps the grant (see REQ-028), go to e_issue with grant unchanged; otherwise set rr_ptr = grant+1 (wrapping from num_req_p-1 to 0) and go to e_arb.
REQ-022 Requesters that are not granted keep their byte and valid asserted; no byte is dropped or duplicated.
REQ-023 The arbiter does not inspect tx_done_i outside e_wait; a stray pulse in e_arb or e_issue is ignored.
REQ-024 Arbitration fairness: under continuous requests from all requesters, each requester is served once per num_req_p released grants.
REQ-025 tx_data_o is 0 whenever tx_v_o is low.

Reset
REQ-026 While reset_n_i is low, asynchronously: state = e_arb, rr_ptr = 0, grant = 0, last_r = 0; tx_v_o, tx_data_o, req_ready_and_o and busy_o are all 0.
REQ-027 Reset asserted mid-frame aborts ownership immediately; after release, arbitration restarts from requester 0 with no dependence on prior state.

Configuration
REQ-028 Macro UART_TX_ARB_LOCK_EN defined: the grant is held across bytes until a byte with last set completes, so a message is never interleaved. While the owner is in e_issue waiting for its next byte, the grant is held indefinitely.
REQ-029 Macro UART_TX_ARB_LOCK_EN undefined: req_last_i is ignored and the grant is released after every byte (per-byte round robin).

Verification
REQ-030 Single requester: req 2 sends 0xA5 with last=1 -> tx_data_o=0xA5 with tx_v_o on the handshake cycle; after tx_done_i, busy_o=0 and rr_ptr=3.
REQ-031 Contention, all four requesters valid, rr_ptr=0, single-byte messages -> serve order 0,1,2,3,0 with one frame each.
REQ-032 Lock enabled: req 1 sends 0x11,0x22,0x33(last) while req 0 is valid with 0x44 -> uart sees 11,22,33,44; with lock disabled -> 11,44,22,...
REQ-033 Lock enabled, owner deasserts valid between bytes for 50 cycles -> grant_o is held and no other requester gets ready_and.
REQ-034 Assert reset_n_i low during e_wait -> tx_v_o=0, busy_o=0 with no clock edge; after release, requester 0 is granted first.
REQ-035 Wrap: rr_ptr=3 with requests from 0 and 3 -> 3 is served, then 0.
